// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: state encoding, widths,
// and the alignment helper used by the access stage.
package dmem_responder_pkg;

  localparam int DMEM_ADDR_W = 8;
  localparam int BYTE_OFF_W  = 2;
  localparam int DATA_W      = 32;
  localparam int CNT_W       = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  function automatic logic is_misaligned(input logic [BYTE_OFF_W-1:0] byte_off);
    return byte_off != '0;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage: one synchronous write port, one combinational read port,
// every word cleared by the asynchronous reset.
module dmem_array
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_W = DMEM_ADDR_W
) (
  input  logic                       clk,
  input  logic                       areset,
  input  logic                       we,
  input  logic [ADDR_W-BYTE_OFF_W-1:0] waddr,
  input  logic [DATA_W-1:0]          wdata,
  input  logic [ADDR_W-BYTE_OFF_W-1:0] raddr,
  output logic [DATA_W-1:0]          rdata
);

  localparam int WORDS = 2 ** (ADDR_W - BYTE_OFF_W);

  logic [DATA_W-1:0] mem_q [WORDS];

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      for (int i = 0; i < WORDS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/dmem_responder.sv
// Valid/ready data-memory responder: one outstanding request, programmable
// access latency, response held until the initiator accepts it.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_W  = DMEM_ADDR_W,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              areset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int               IDX_W    = ADDR_W - BYTE_OFF_W;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               err_q, err_d;

  logic               wr_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;

  logic               capture;
  logic               mem_we;
  logic [DATA_W-1:0]  mem_rdata;
  logic [IDX_W-1:0]   word_idx;

  assign word_idx = addr_q[ADDR_W-1:BYTE_OFF_W];

  dmem_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk    (clk),
    .areset (areset),
    .we     (mem_we),
    .waddr  (word_idx),
    .wdata  (wdata_q),
    .raddr  (word_idx),
    .rdata  (mem_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    capture = 1'b0;
    mem_we  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          capture = 1'b1;
          cnt_d   = CNT_LOAD;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          // Access happens on the edge that enters RESP; misaligned requests never touch storage.
          state_d = ST_RESP;
          if (is_misaligned(addr_q[BYTE_OFF_W-1:0])) begin
            rdata_d = '0;
            err_d   = 1'b1;
          end else begin
            err_d   = 1'b0;
            rdata_d = wr_q ? '0 : mem_rdata;
            mem_we  = wr_q;
          end
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Request payload is only meaningful while BUSY, so it carries no reset.
  always_ff @(posedge clk) begin
    if (capture) begin
      wr_q    <= req_write;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench: expected responses queued at request acceptance, popped
// by a monitor on every response handshake; two instances (LATENCY 2 and 1).
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        areset;

  logic        req_valid2, req_ready2, req_write2, rsp_valid2, rsp_ready2, rsp_err2;
  logic [7:0]  req_addr2;
  logic [31:0] req_wdata2, rsp_rdata2;

  logic        req_valid1, req_ready1, req_write1, rsp_valid1, rsp_ready1, rsp_err1;
  logic [7:0]  req_addr1;
  logic [31:0] req_wdata1, rsp_rdata1;

  dmem_responder #(.ADDR_W(8), .LATENCY(2)) u_dut2 (
    .clk       (clk),
    .areset    (areset),
    .req_valid (req_valid2),
    .req_ready (req_ready2),
    .req_write (req_write2),
    .req_addr  (req_addr2),
    .req_wdata (req_wdata2),
    .rsp_valid (rsp_valid2),
    .rsp_ready (rsp_ready2),
    .rsp_rdata (rsp_rdata2),
    .rsp_err   (rsp_err2)
  );

  dmem_responder #(.ADDR_W(8), .LATENCY(1)) u_dut1 (
    .clk       (clk),
    .areset    (areset),
    .req_valid (req_valid1),
    .req_ready (req_ready1),
    .req_write (req_write1),
    .req_addr  (req_addr1),
    .req_wdata (req_wdata1),
    .rsp_valid (rsp_valid1),
    .rsp_ready (rsp_ready1),
    .rsp_rdata (rsp_rdata1),
    .rsp_err   (rsp_err1)
  );

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t q2[$];
  exp_t q1[$];

  int nchk  = 0;
  int npass = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic        v_wr    [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  logic [7:0]  v_addr  [4] = '{8'h20, 8'h20, 8'h24, 8'h24};
  logic [31:0] v_wdata [4] = '{32'hA5A5A5A5, 32'h0, 32'h5A5A0001, 32'h0};
  logic [31:0] v_exp   [4] = '{32'h0, 32'hA5A5A5A5, 32'h0, 32'h5A5A0001};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rsp_valid2 && rsp_ready2) begin
        if (q2.size() == 0) chk("rsp2_unexpected", 32'd1, 32'd0);
        else begin
          e = q2.pop_front();
          chk("rsp2_rdata", rsp_rdata2, e.rdata);
          chk("rsp2_err", 32'(rsp_err2), 32'(e.err));
        end
      end
      if (rsp_valid1 && rsp_ready1) begin
        if (q1.size() == 0) chk("rsp1_unexpected", 32'd1, 32'd0);
        else begin
          e = q1.pop_front();
          chk("rsp1_rdata", rsp_rdata1, e.rdata);
          chk("rsp1_err", 32'(rsp_err1), 32'(e.err));
        end
      end
    end
  endtask

  task automatic wait_ready2();
    int n = 0;
    while (!req_ready2 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!req_ready2) chk("req_ready2_timeout", 32'd0, 32'd1);
  endtask

  task automatic issue2(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err, input logic push);
    wait_ready2();
    req_valid2 = 1'b1;
    req_write2 = wr;
    req_addr2  = addr;
    req_wdata2 = wd;
    @(posedge clk); #1;
    req_valid2 = 1'b0;
    req_write2 = ~wr;
    req_addr2  = 8'hFF;
    req_wdata2 = 32'h0BAD0BAD;
    if (push) q2.push_back('{rdata: exp_rd, err: exp_err});
  endtask

  task automatic wait_rsp2(input string name);
    int c = 0;
    while (!rsp_valid2 && c < 50) begin
      @(posedge clk); #1; c++;
    end
    chk(name, 32'(c), 32'd2);
  endtask

  task automatic wait_rsp1(input string name);
    int c = 0;
    while (!rsp_valid1 && c < 50) begin
      @(posedge clk); #1; c++;
    end
    chk(name, 32'(c), 32'd1);
  endtask

  initial begin
    int n;
    int acc;
    int prev_acc;
    areset     = 1'b0;
    req_valid2 = 1'b0; req_write2 = 1'b0; req_addr2 = '0; req_wdata2 = '0; rsp_ready2 = 1'b1;
    req_valid1 = 1'b0; req_write1 = 1'b0; req_addr1 = '0; req_wdata1 = '0; rsp_ready1 = 1'b1;
    prev_acc   = 0;

    fork
      monitor();
    join_none

    repeat (3) @(posedge clk);
    #1 areset = 1'b1;
    @(posedge clk); #1;
    chk("rst_req_ready2", 32'(req_ready2), 32'd1);
    chk("rst_rsp_valid2", 32'(rsp_valid2), 32'd0);
    chk("rst_rdata2", rsp_rdata2, 32'd0);
    chk("rst_err2", 32'(rsp_err2), 32'd0);
    chk("rst_req_ready1", 32'(req_ready1), 32'd1);
    chk("rst_rsp_valid1", 32'(rsp_valid1), 32'd0);

    issue2(1'b0, 8'h10, 32'h0, 32'h0, 1'b0, 1'b1);
    wait_rsp2("lat_load10");

    issue2(1'b1, 8'h08, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1);
    wait_rsp2("lat_store08");
    issue2(1'b0, 8'h08, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1);
    wait_rsp2("lat_load08");

    // Backpressure: response must hold while a competing request is refused.
    wait_ready2();
    rsp_ready2 = 1'b0;
    issue2(1'b0, 8'h08, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1);
    wait_rsp2("lat_bp");
    req_valid2 = 1'b1; req_write2 = 1'b1; req_addr2 = 8'h08; req_wdata2 = 32'h11111111;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_rsp_valid", 32'(rsp_valid2), 32'd1);
      chk("bp_rdata", rsp_rdata2, 32'hDEADBEEF);
      chk("bp_req_ready", 32'(req_ready2), 32'd0);
      @(posedge clk); #1;
    end
    req_valid2 = 1'b0;
    rsp_ready2 = 1'b1;

    issue2(1'b1, 8'h09, 32'h12345678, 32'h0, 1'b1, 1'b1);
    wait_rsp2("lat_misaligned");
    issue2(1'b0, 8'h08, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1);
    wait_rsp2("lat_load08_after_mis");

    // Reset while BUSY drops the pending store.
    issue2(1'b1, 8'h0C, 32'hCAFEF00D, 32'h0, 1'b0, 1'b0);
    chk("busy_req_ready", 32'(req_ready2), 32'd0);
    areset = 1'b0;
    #2;
    chk("midrst_rsp_valid", 32'(rsp_valid2), 32'd0);
    chk("midrst_req_ready", 32'(req_ready2), 32'd1);
    @(posedge clk); #1;
    areset = 1'b1;
    @(posedge clk); #1;
    chk("postrst_req_ready", 32'(req_ready2), 32'd1);
    chk("postrst_rsp_valid", 32'(rsp_valid2), 32'd0);
    issue2(1'b0, 8'h0C, 32'h0, 32'h0, 1'b0, 1'b1);
    wait_rsp2("lat_load0C");

    // LATENCY=1 instance, request held continuously, rsp_ready tied high.
    for (int i = 0; i < 4; i++) begin
      n = 0;
      while (!req_ready1 && n < 50) begin
        @(posedge clk); #1; n++;
      end
      if (!req_ready1) chk("req_ready1_timeout", 32'd0, 32'd1);
      req_valid1 = 1'b1;
      req_write1 = v_wr[i];
      req_addr1  = v_addr[i];
      req_wdata1 = v_wdata[i];
      @(posedge clk); #1;
      acc = cyc;
      q1.push_back('{rdata: v_exp[i], err: 1'b0});
      if (i > 0) chk("period1", 32'(acc - prev_acc), 32'd3);
      prev_acc = acc;
      if (i == 3) req_valid1 = 1'b0;
      wait_rsp1("lat1");
    end

    repeat (4) @(posedge clk);
    #1;
    chk("q2_drained", 32'(q2.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
